stack_seq: RTL and testbench

Instruction sequencer that drives the 6-entry operand stack (stack6) of the RPN calculator datapath. It accepts one opcode per valid/ready handshake and generates stack6's load/push/pop/d controls from its qtop/qnext outputs. It contains the ALU, the depth tracker and the overflow/underflow guards. Results leave through a registered OUT port.

---
 rtl/stack_seq.sv | 212 +++++++++++++++++++++
 tb/tb_stack_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Purpose : RPN instruction sequencer driving a stack6 operand stack (ALU, depth tracking, guards).
// Latency : stack controls are combinational in the accept cycle; OUT result is registered (+1 cycle).
// Backpressure: in_ready drops for the two extra cycles of SWAP; every other op is accepted at 1/cycle.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      instruction handshake; opcode + imm qualify the instruction
//   qtop, qnext            top two entries read back from stack6
//   load, push, pop, d     stack6 controls and write data
//   depth                  number of valid stack entries (0..DEPTH)
//   out_valid, out_data    one-cycle pulse with the value captured by OUT
//   err_ovf, err_unf       sticky overflow / underflow flags
module stack_seq #(
    parameter int W     = 16,
    parameter int DEPTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   opcode,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] qtop,
    input  logic [W-1:0] qnext,
    output logic         load,
    output logic         push,
    output logic         pop,
    output logic [W-1:0] d,
    output logic [2:0]   depth,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         err_ovf,
    output logic         err_unf
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSHI = 3'b001;
    localparam logic [2:0] OP_DROP  = 3'b010;
    localparam logic [2:0] OP_DUP   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_OUT   = 3'b111;

    localparam logic [2:0] DMAX = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SW2  = 2'd1,
        SW3  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [2:0]   depth_nxt;
    logic [W-1:0] tmp0, tmp1;
    logic         tmp0_en, tmp1_en;
    logic         out_fire;
    logic         ovf_set, unf_set;
    logic         accept;

    // Operand-availability guards, evaluated against the current depth.
    logic has1, has2, room;

    assign has1 = (depth >= 3'd1);
    assign has2 = (depth >= 3'd2);
    assign room = (depth < DMAX);

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        load      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        d         = '0;
        tmp0_en   = 1'b0;
        tmp1_en   = 1'b0;
        out_fire  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_NOP: ;
                        OP_PUSHI: begin
                            if (room) begin
                                load      = 1'b1;
                                push      = 1'b1;
                                d         = imm;
                                depth_nxt = depth + 3'd1;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            // An empty stack is an operand shortage, not an overflow,
                            // even when DEPTH would otherwise allow the push.
                            if (!has1) begin
                                unf_set = 1'b1;
                            end else if (!room) begin
                                ovf_set = 1'b1;
                            end else begin
                                push      = 1'b1;
                                depth_nxt = depth + 3'd1;
                            end
                        end
                        OP_DROP: begin
                            if (has1) begin
                                pop       = 1'b1;
                                depth_nxt = depth - 3'd1;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (has2) begin
                                load      = 1'b1;
                                pop       = 1'b1;
                                // RPN order: "a b -" yields a - b, a sits in qnext.
                                d         = (opcode == OP_ADD) ? (qnext + qtop) : (qnext - qtop);
                                depth_nxt = depth - 3'd1;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            // Step 1 of 3: remember the old top and pop it off.
                            if (has2) begin
                                tmp0_en   = 1'b1;
                                pop       = 1'b1;
                                state_nxt = SW2;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (has1) begin
                                out_fire = 1'b1;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SW2: begin
                // Old second entry is now on top: save it and overwrite with old top.
                tmp1_en   = 1'b1;
                load      = 1'b1;
                d         = tmp0;
                state_nxt = SW3;
            end
            SW3: begin
                // Push the old second entry back above the old top.
                load      = 1'b1;
                push      = 1'b1;
                d         = tmp1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Keep stack6 quiet for the whole time reset is held, including mid-swap.
        if (rst) begin
            load = 1'b0;
            push = 1'b0;
            pop  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            depth     <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            depth     <= depth_nxt;
            out_valid <= out_fire;
            if (out_fire) begin
                out_data <= qtop;
            end
            if (ovf_set) begin
                err_ovf <= 1'b1;
            end
            if (unf_set) begin
                err_unf <= 1'b1;
            end
        end
    end

    // Swap scratch registers carry no meaning outside SW2/SW3, so no reset.
    always_ff @(posedge clk) begin
        if (tmp0_en) begin
            tmp0 <= qtop;
        end
        if (tmp1_en) begin
            tmp1 <= qtop;
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;

    localparam int W = 16;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSHI = 3'b001;
    localparam logic [2:0] OP_DROP  = 3'b010;
    localparam logic [2:0] OP_DUP   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_OUT   = 3'b111;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] imm;
    logic [W-1:0] qtop;
    logic [W-1:0] qnext;
    logic         load;
    logic         push;
    logic         pop;
    logic [W-1:0] d;
    logic [2:0]   depth;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         err_ovf;
    logic         err_unf;

    int n_chk  = 0;
    int n_fail = 0;

    // Values of the stack controls seen in the accept cycle of the last issued op.
    logic         c_load, c_push, c_pop, c_rdy;
    logic [W-1:0] c_d;

    stack_seq #(.W(W), .DEPTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .imm      (imm),
        .qtop     (qtop),
        .qnext    (qnext),
        .load     (load),
        .push     (push),
        .pop      (pop),
        .d        (d),
        .depth    (depth),
        .out_valid(out_valid),
        .out_data (out_data),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack6: entry 0 is the top.
    logic [W-1:0] stk [6];

    initial begin
        for (int i = 0; i < 6; i++) stk[i] = '0;
    end

    always @(posedge clk) begin
        if (push) begin
            for (int i = 5; i > 0; i--) stk[i] <= stk[i-1];
            if (load) stk[0] <= d;
        end else if (pop) begin
            for (int i = 0; i < 5; i++) stk[i] <= stk[i+1];
            if (load) stk[0] <= d;
        end else if (load) begin
            stk[0] <= d;
        end
    end

    assign qtop  = stk[0];
    assign qnext = stk[1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the op's commit edge.
    task automatic issue(input logic [2:0] opc, input logic [W-1:0] v);
        in_valid = 1'b1;
        opcode   = opc;
        imm      = v;
        @(negedge clk);
        c_load = load;
        c_push = push;
        c_pop  = pop;
        c_d    = d;
        c_rdy  = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = OP_NOP;
        imm      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_ovf", 32'(err_ovf), 32'd0);
        check("rst_unf", 32'(err_unf), 32'd0);
        check("rst_ctl", {29'd0, load, push, pop}, 32'd0);
        check("rst_oval", 32'(out_valid), 32'd0);
        check("rst_odat", 32'(out_data), 32'd0);
        #1 rst = 1'b0;
        tick();
        check("rst_rdy_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = OP_NOP;
        imm      = '0;
        #1;
        check("init_depth", 32'(depth), 32'd0);
        check("init_rdy", 32'(in_ready), 32'd0);
        check("init_odat", 32'(out_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("init_rdy_after", 32'(in_ready), 32'd1);

        // 3 + 5 = 8
        issue(OP_PUSHI, 16'd3);
        issue(OP_PUSHI, 16'd5);
        issue(OP_ADD, '0);
        check("add_ctl", {29'd0, c_load, c_push, c_pop}, 32'b101);
        check("add_d", 32'(c_d), 32'h8);
        check("add_qtop", 32'(qtop), 32'h8);
        check("add_depth", 32'(depth), 32'd1);
        issue(OP_OUT, '0);
        check("out1_vld", 32'(out_valid), 32'd1);
        check("out1_dat", 32'(out_data), 32'h0008);
        tick();
        check("out1_pulse", 32'(out_valid), 32'd0);
        check("out1_hold", 32'(out_data), 32'h0008);
        issue(OP_DROP, '0);

        // 3 - 10 wraps to 0xFFF9
        issue(OP_PUSHI, 16'd3);
        issue(OP_PUSHI, 16'd10);
        issue(OP_SUB, '0);
        issue(OP_OUT, '0);
        check("sub_dat", 32'(out_data), 32'hFFF9);
        check("sub_depth", 32'(depth), 32'd1);
        issue(OP_DROP, '0);

        // 0xFFFF + 2 wraps to 1
        issue(OP_PUSHI, 16'hFFFF);
        issue(OP_PUSHI, 16'd2);
        issue(OP_ADD, '0);
        issue(OP_OUT, '0);
        check("wrap_dat", 32'(out_data), 32'h0001);
        issue(OP_DROP, '0);
        check("empty_depth", 32'(depth), 32'd0);

        // SWAP with a following instruction held valid
        issue(OP_PUSHI, 16'd1);
        issue(OP_PUSHI, 16'd2);
        issue(OP_PUSHI, 16'd3);
        in_valid = 1'b1;
        opcode   = OP_SWAP;
        @(negedge clk);
        check("swap_rdy0", 32'(in_ready), 32'd1);
        tick();
        opcode = OP_NOP;
        @(negedge clk);
        check("swap_rdy1", 32'(in_ready), 32'd0);
        check("swap_sw2_ctl", {29'd0, load, push, pop}, 32'b100);
        tick();
        @(negedge clk);
        check("swap_rdy2", 32'(in_ready), 32'd0);
        check("swap_sw3_ctl", {29'd0, load, push, pop}, 32'b110);
        tick();
        @(negedge clk);
        check("swap_rdy3", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("swap_qtop", 32'(qtop), 32'd2);
        check("swap_qnext", 32'(qnext), 32'd3);
        check("swap_depth", 32'(depth), 32'd3);
        issue(OP_DROP, '0);
        issue(OP_DROP, '0);
        issue(OP_OUT, '0);
        check("swap_entry3", 32'(out_data), 32'd1);
        check("swap_noerr", {30'd0, err_ovf, err_unf}, 32'd0);
        issue(OP_DROP, '0);

        // Overflow: seven pushes into a 6-entry stack
        for (int i = 0; i < 6; i++) issue(OP_PUSHI, 16'(i));
        check("ovf_pre", 32'(err_ovf), 32'd0);
        issue(OP_PUSHI, 16'd6);
        check("ovf_ctl", {29'd0, c_load, c_push, c_pop}, 32'd0);
        check("ovf_flag", 32'(err_ovf), 32'd1);
        check("ovf_unf", 32'(err_unf), 32'd0);
        check("ovf_depth", 32'(depth), 32'd6);
        check("ovf_qtop", 32'(qtop), 32'd5);
        issue(OP_NOP, '0);
        check("ovf_sticky", 32'(err_ovf), 32'd1);

        // Mid-cycle async reset, then underflow on ADD
        do_reset();
        issue(OP_PUSHI, 16'd9);
        issue(OP_ADD, '0);
        check("unf_ctl", {29'd0, c_load, c_push, c_pop}, 32'd0);
        check("unf_rdy", 32'(c_rdy), 32'd1);
        check("unf_flag", 32'(err_unf), 32'd1);
        check("unf_ovf", 32'(err_ovf), 32'd0);
        check("unf_depth", 32'(depth), 32'd1);
        check("unf_qtop", 32'(qtop), 32'd9);
        issue(OP_OUT, '0);
        check("unf_out", 32'(out_data), 32'd9);

        // DUP on an empty stack: underflow only
        do_reset();
        issue(OP_DUP, '0);
        check("dup0_ctl", {29'd0, c_load, c_push, c_pop}, 32'd0);
        check("dup0_flags", {30'd0, err_ovf, err_unf}, 32'b01);
        check("dup0_depth", 32'(depth), 32'd0);
        issue(OP_PUSHI, 16'h0042);
        issue(OP_DUP, '0);
        check("dup_depth", 32'(depth), 32'd2);
        check("dup_qnext", 32'(qnext), 32'h0042);

        // Reset during SW2 aborts the swap
        do_reset();
        issue(OP_PUSHI, 16'd1);
        issue(OP_PUSHI, 16'd2);
        issue(OP_SWAP, '0);
        check("abort_sw2", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("abort_ctl", {29'd0, load, push, pop}, 32'd0);
        check("abort_depth", 32'(depth), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_rdy", 32'(in_ready), 32'd1);
        check("abort_ctl_after", {29'd0, load, push, pop}, 32'd0);
        tick();
        @(negedge clk);
        check("abort_ctl_next", {29'd0, load, push, pop}, 32'd0);
        check("abort_depth_next", 32'(depth), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
